// File: rtl/ysyx_ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
//   - FSM state encoding (2 bits)
//   - default reset fetch address
//   - fetch packet type carried by the output register
//   - next sequential pc helper
package ysyx_ifu_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

   localparam logic [1:0] S_REQ  = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } fetch_pkt_t;

   function automatic logic [31:0] seq_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/ysyx_ifu_if.sv
// Instruction memory request/response bus.
//   req_valid/req_ready/req_addr : fetch request handshake
//   resp_valid/resp_data         : one-cycle response pulse per accepted request
// master = fetch unit side, slave = memory side.
interface ysyx_ifu_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic [31:0] resp_data;

   modport master (
      output req_valid, req_addr,
      input  req_ready, resp_valid, resp_data
   );

   modport slave (
      input  req_valid, req_addr,
      output req_ready, resp_valid, resp_data
   );
endinterface

// File: rtl/ysyx_pipe_reg.sv
// Valid/ready output register holding the fetched instruction and its pc
// toward decode.
//   clk, rst_n      : clock, async active-low reset
//   load, load_pkt  : capture a new packet (sets out_valid)
//   flush           : discard the held packet
//   out_valid/ready : handshake toward decode
//   out_pkt         : held instruction/pc, stable until handshake or flush
module ysyx_pipe_reg
   import ysyx_ifu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  fetch_pkt_t load_pkt,
   input  logic       flush,
   output logic       out_valid,
   input  logic       out_ready,
   output fetch_pkt_t out_pkt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_pkt   <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_pkt   <= load_pkt;
      end else if (flush || (out_valid && out_ready)) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/ysyx_ifu.sv
// Instruction fetch unit: one outstanding request, response buffered in an
// output register toward decode, redirects from execute override pc+4.
//   clk, rst_n          : clock, async active-low reset
//   imem                : instruction memory bus (master side)
//   redirect_valid/pc   : control-flow change from execute
//   out_valid/ready     : handshake toward decode
//   out_inst, out_pc    : delivered instruction and its address
//   fetch_cnt           : instructions handed to decode (wraps)
//
// state  | meaning
// S_REQ  | request pending on imem
// S_WAIT | request accepted, awaiting response
// S_OUT  | instruction held for decode
module ysyx_ifu
   import ysyx_ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   ysyx_ifu_if.master         imem,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_inst,
   output logic [31:0]        out_pc,
   output logic [31:0]        fetch_cnt
);

   logic [1:0]  state;
   logic [31:0] pc;
   logic        kill;
   // Low during reset and the cycle after release so the first request
   // appears on the first edge after rst_n rises.
   logic        run;
   logic        req_fire;
   logic        out_fire;
   logic        load;
   fetch_pkt_t  load_pkt;
   fetch_pkt_t  out_pkt;

   assign imem.req_valid = run && (state == S_REQ);
   assign imem.req_addr  = pc;
   assign req_fire       = imem.req_valid && imem.req_ready;
   assign out_fire       = out_valid && out_ready;

   // A response is only kept if nothing redirected fetch since it was issued.
   assign load          = (state == S_WAIT) && imem.resp_valid && !kill && !redirect_valid;
   assign load_pkt.inst = imem.resp_data;
   assign load_pkt.pc   = pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_REQ;
         pc        <= RESET_PC;
         kill      <= 1'b0;
         fetch_cnt <= '0;
         run       <= 1'b0;
      end else begin
         run <= 1'b1;
         if (out_fire) fetch_cnt <= fetch_cnt + 32'd1;
         case (state)
            S_REQ: begin
               if (redirect_valid) pc <= redirect_pc;
               if (req_fire) begin
                  state <= S_WAIT;
                  kill  <= redirect_valid;
               end
            end
            S_WAIT: begin
               // pc doubles as the saved redirect target while waiting.
               if (redirect_valid) begin
                  pc   <= redirect_pc;
                  kill <= 1'b1;
               end
               if (imem.resp_valid) begin
                  state <= (kill || redirect_valid) ? S_REQ : S_OUT;
                  kill  <= 1'b0;
               end
            end
            S_OUT: begin
               if (redirect_valid) begin
                  pc    <= redirect_pc;
                  state <= S_REQ;
               end else if (out_fire) begin
                  pc    <= seq_pc(pc);
                  state <= S_REQ;
               end
            end
            default: state <= S_REQ;
         endcase
      end
   end

   ysyx_pipe_reg u_pipe_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_pkt  (load_pkt),
      .flush     (redirect_valid),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pkt   (out_pkt)
   );

   assign out_inst = out_pkt.inst;
   assign out_pc   = out_pkt.pc;

endmodule

// File: doc/ysyx_ifu.md
YSYX_IFU -- requirements
Module: ysyx_ifu

Interface
REQ-001 Parameter: RESET_PC, default 32'h8000_0000, address of the first fetch after reset.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 imem_req_valid  out  1  fetch request valid.
REQ-005 imem_req_ready  in  1  memory accepts request.
REQ-006 imem_req_addr  out  32  fetch address; always equals the internal pc.
REQ-007 imem_resp_valid  in  1  instruction word returned; one cycle pulse per accepted request.
REQ-008 imem_resp_data  in  32  instruction word.
REQ-009 redirect_valid  in  1  control-flow change from execute (jump or taken branch).
REQ-010 redirect_pc  in  32  redirect target.
REQ-011 out_valid  out  1  inst/pc valid toward decode.
REQ-012 out_ready  in  1  decode accepts inst/pc.
REQ-013 out_inst  out  32  fetched instruction.
REQ-014 out_pc  out  32  address of out_inst.
REQ-015 fetch_cnt  out  32  count of instructions handed to decode.

Function
REQ-016 FSM states: S_REQ (request pending), S_WAIT (awaiting response), S_OUT (holding instruction for decode).
REQ-017 S_REQ: imem_req_valid=1; on imem_req_valid&imem_req_ready -> S_WAIT.
REQ-018 S_WAIT: imem_req_valid=0; on imem_resp_valid, capture imem_resp_data and pc into output register -> S_OUT.
REQ-019 S_OUT: out_valid=1, out_inst/out_pc stable until handshake; on out_valid&out_ready, pc <= pc+4 (mod 2^32), fetch_cnt += 1 (wraps), -> S_REQ.
REQ-020 Exactly one request outstanding; no new request while in S_WAIT or S_OUT.
REQ-021 Minimum latency: request accepted cycle N, response N+1, out_valid at N+2; back-to-back throughput one instruction per 3 cycles with always-ready memory and decode.
REQ-022 Redirect in S_REQ: pc <= redirect_pc; if request accepted same cycle, the accepted address is the old pc and the response is discarded (kill flag set), then S_REQ at redirect_pc.
REQ-023 Redirect in S_WAIT: set kill flag, save redirect_pc; arriving response is dropped, out_valid stays 0, then -> S_REQ with pc = saved target.
REQ-024 Redirect in S_WAIT on the same cycle as imem_resp_valid: response dropped, -> S_REQ at redirect_pc.
REQ-025 Redirect in S_OUT without handshake: buffered instruction discarded, fetch_cnt unchanged, pc <= redirect_pc, -> S_REQ.
REQ-026 Redirect in S_OUT coincident with out_valid&out_ready: instruction counts as delivered (fetch_cnt += 1), pc <= redirect_pc (not pc+4), -> S_REQ.
REQ-027 Redirect always overrides pc+4; redirect_pc[1:0] is used unmodified.
REQ-028 out_valid is never deasserted before handshake except by redirect.

Reset
REQ-029 While rst_n=0: state=S_REQ, pc=RESET_PC, kill=0, out_valid=0, out_inst=0, out_pc=0, fetch_cnt=0, imem_req_valid=0.
REQ-030 First rising edge after rst_n release: imem_req_valid=1, imem_req_addr=RESET_PC.
REQ-031 Reset mid-transaction abandons any outstanding request; a late imem_resp_valid in the first cycle after reset is ignored.

Structure
REQ-032 Shared package holds FSM state encoding (2 bits) and RESET_PC default.
REQ-033 One sub-module: ysyx_pipe_reg, the valid/ready output register holding out_inst/out_pc.

Verification
REQ-034 Reset release, memory and decode always ready, mem returns 32'h00100093 -> out_pc 32'h8000_0000 at cycle 2, next request addr 32'h8000_0004, fetch_cnt=1.
REQ-035 out_ready held 0 for 5 cycles in S_OUT -> out_valid, out_inst, out_pc stable; no imem_req_valid; fetch_cnt unchanged.
REQ-036 redirect_valid with redirect_pc 32'h8000_0100 during S_WAIT -> returned word dropped, next imem_req_addr 32'h8000_0100, no out_valid for old pc.
REQ-037 Redirect coincident with out handshake at pc 32'h8000_0008 -> fetch_cnt increments, next request addr = redirect_pc, not 32'h8000_000C.
REQ-038 imem_req_ready held 0 for 4 cycles -> imem_req_valid and imem_req_addr stable throughout.
REQ-039 rst_n asserted in S_WAIT -> outputs return to reset values immediately; fetch restarts at 32'h8000_0000.
